mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single synchronous RAM port between the core's instruction-fetch requester and its load/store requester. It sits between the CPU control FSM and the memory: it accepts one request per transaction, grants one requester, drives the RAM for one cycle, waits the RAM read latency, and returns data or a write acknowledge to the winner. Fetch and data accesses are fully serialised; at most one transaction is outstanding.

## Interface
- AW, 7, word-address width (RAM depth 2^AW words)
- DW, 32, data width
- MEM_LAT, 1, RAM read latency in cycles (1..7); rdata is valid MEM_LAT cycles after mem_en

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  AW  fetch word address
- i_gnt  out  1  one-cycle fetch grant pulse
- i_rvalid  out  1  one-cycle fetch data valid
- i_rdata  out  DW  fetch data, valid with i_rvalid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_gnt  out  1  one-cycle data grant pulse
- d_rvalid  out  1  one-cycle load data valid / store acknowledge
- d_rdata  out  DW  load data, valid with d_rvalid (0 for stores)
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_be  out  DW/8  RAM byte enables
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if any req, choose winner (see Configuration); same cycle assert winner's gnt, mem_en=1, mem_addr/mem_we/mem_be/mem_wdata from winner (fetch: mem_we=0, mem_be=all ones). Register winner id (`owner`) and store flag; load wait counter with MEM_LAT-1; go to WAIT if MEM_LAT>1, else RESP. No req: mem_en=0, stay IDLE.
- WAIT: decrement counter; at 0 go to RESP. No grants, mem_en=0.
- RESP: assert owner's rvalid for exactly one cycle; rdata = mem_rdata (loads/fetches) or 0 (stores). Non-owner rvalid stays 0. Update last-winner pointer. Go to IDLE.
- Requests arriving in WAIT/RESP are held by the requester and considered in the next IDLE cycle.
- gnt is combinational from state and req; mem_* are combinational in IDLE and 0 otherwise; rvalid/rdata are driven in RESP from registered owner.
- Deassertion of req before gnt is legal (request withdrawn); after gnt the transaction always completes.

## Timing
- Reset values: i_gnt=d_gnt=0, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, mem_en=mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; state IDLE; last-winner = data (so fetch wins the first contested cycle in round-robin mode).
- Grant latency: gnt in the first cycle req is high while IDLE (0 cycles).
- Response latency: rvalid exactly MEM_LAT cycles after gnt.
- Throughput: one transaction every MEM_LAT+1 cycles; back-to-back requests from the same requester alternate IDLE/RESP at MEM_LAT=1.
- Simultaneous i_req and d_req in IDLE: exactly one gnt; the loser's gnt stays 0 and it is served next IDLE if still requesting.
- rst asserted mid-transaction: next cycle state IDLE, outstanding transaction dropped, no rvalid issued; a store already strobed to RAM is not undone.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention, winner is the requester that did not win the previous transaction (pointer updated in RESP only).
- Not defined: fixed priority, data (d_req) always beats fetch (i_req); last-winner pointer omitted.

## Test plan
- Single fetch, MEM_LAT=1: i_req=1, i_addr=5, RAM[5]=0x00500093 -> i_gnt same cycle, mem_en=1, mem_addr=5, mem_we=0; next cycle i_rvalid=1, i_rdata=0x00500093; d_rvalid stays 0.
- Store then load: d_req, d_we=1, d_addr=3, d_wdata=0xDEADBEEF, d_be=4'b1100 on RAM 0 -> d_rvalid with d_rdata=0; following load of 3 returns 0xDEAD0000.
- Contention, ARB_ROUND_ROBIN_EN: i_req and d_req held high for 4 transactions -> grant order fetch, data, fetch, data; without macro -> data every time, fetch never granted while d_req held.
- MEM_LAT=3: single load at cycle 0 -> mem_en only cycle 0, rvalid at cycle 3; d_req raised at cycle 1 not granted until cycle 4.
- Reset mid-op: rst at cycle 1 after fetch gnt at cycle 0 (MEM_LAT=2) -> no i_rvalid ever, all outputs 0 at cycle 2, new i_req at cycle 3 granted at cycle 3.
- Withdrawn request: d_req pulses high only during a WAIT cycle -> no d_gnt, no RAM access for it.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one synchronous RAM port between the instruction-fetch requester
// (i_*) and the load/store requester (d_*). Exactly one transaction is in
// flight at a time: IDLE grants and strobes the RAM, WAIT covers the remaining
// RAM read latency, and RESP returns data (or a store acknowledge) to the
// requester that won.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined     - on contention, the requester that lost the previous
//                 transaction wins (alternating service)
//   not defined - fixed priority, the data requester always beats fetch
//
// Parameters:
//   AW      word-address width (RAM depth 2^AW)
//   DW      data width
//   MEM_LAT RAM read latency in cycles (1..7)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_req/i_addr          fetch request and word address
//   i_gnt                 one-cycle fetch grant
//   i_rvalid/i_rdata      one-cycle fetch data return
//   d_req/d_we/d_addr/
//   d_wdata/d_be          load/store request
//   d_gnt                 one-cycle data grant
//   d_rvalid/d_rdata      load data / store acknowledge (rdata 0 for stores)
//   mem_en/mem_we/mem_be/
//   mem_addr/mem_wdata    RAM strobe and write side (valid only while granting)
//   mem_rdata             RAM read data, valid MEM_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW      = 7,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int BW = DW / 8;
    // Counter preload: number of WAIT cycles still to spend after IDLE.
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_reg;
    logic [2:0] cnt_reg;
    logic       owner_reg;   // 1 = data requester owns the transaction
    logic       store_reg;   // owning transaction is a store

    logic       take;        // a grant is issued this cycle
    logic       pick_d;      // data requester wins the arbitration

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_reg;    // 1 = data won the previous transaction

    always_comb begin
        pick_d = d_req;
        // On contention serve whoever did not win last time.
        if (i_req && d_req) begin
            pick_d = ~last_reg;
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    // Grants are suppressed while reset is held so every output reads 0.
    assign take  = (state_reg == IDLE) && !rst && (i_req || d_req);
    assign i_gnt = take && !pick_d;
    assign d_gnt = take && pick_d;

    // RAM side is only driven in the granting cycle, zero otherwise.
    always_comb begin
        mem_en    = take;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_be   = {BW{1'b1}};
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Response side follows the registered owner during RESP.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if ((state_reg == RESP) && !rst) begin
            if (owner_reg) begin
                d_rvalid = 1'b1;
                if (!store_reg) begin
                    d_rdata = mem_rdata;
                end
            end else begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            owner_reg <= 1'b0;
            store_reg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            // Start as if data won last, so fetch takes the first contest.
            last_reg  <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        owner_reg <= pick_d;
                        store_reg <= pick_d && d_we;
                        cnt_reg   <= LAT_M1;
                        state_reg <= (MEM_LAT > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
`ifdef ARB_ROUND_ROBIN_EN
                    last_reg  <= owner_reg;
`endif
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Three instances run side by side with
// MEM_LAT = 1, 2 and 3, each backed by its own byte-enabled RAM model whose
// read data appears MEM_LAT cycles after the access. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Builds with or without ARB_ROUND_ROBIN_EN; the contention expectations
// follow the macro.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int N = 3;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        i_req     [N];
    logic [6:0]  i_addr    [N];
    logic        i_gnt     [N];
    logic        i_rvalid  [N];
    logic [31:0] i_rdata   [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic [6:0]  d_addr    [N];
    logic [31:0] d_wdata   [N];
    logic [3:0]  d_be      [N];
    logic        d_gnt     [N];
    logic        d_rvalid  [N];
    logic [31:0] d_rdata   [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic [3:0]  mem_be    [N];
    logic [6:0]  mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_inst
        localparam int LAT = gi + 1;
        logic [31:0] ram  [128];
        logic [31:0] pipe [LAT];

        mem_arbiter #(.AW(7), .DW(32), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (i_req[gi]),
            .i_addr    (i_addr[gi]),
            .i_gnt     (i_gnt[gi]),
            .i_rvalid  (i_rvalid[gi]),
            .i_rdata   (i_rdata[gi]),
            .d_req     (d_req[gi]),
            .d_we      (d_we[gi]),
            .d_addr    (d_addr[gi]),
            .d_wdata   (d_wdata[gi]),
            .d_be      (d_be[gi]),
            .d_gnt     (d_gnt[gi]),
            .d_rvalid  (d_rvalid[gi]),
            .d_rdata   (d_rdata[gi]),
            .mem_en    (mem_en[gi]),
            .mem_we    (mem_we[gi]),
            .mem_be    (mem_be[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_rdata (mem_rdata[gi])
        );

        // RAM model: clears on reset, byte-enabled writes, read data delayed
        // by LAT cycles from the address presented.
        always @(posedge clk) begin
            if (rst) begin
                for (int a = 0; a < 128; a++) ram[a] <= '0;
            end else if (mem_en[gi] && mem_we[gi]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[gi][b]) ram[mem_addr[gi]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
            end
            pipe[0] <= ram[mem_addr[gi]];
            for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
        end
        assign mem_rdata[gi] = pipe[LAT-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Called one cycle after a grant; counts cycles to the response and
    // leaves the caller at the falling edge of the response cycle.
    task automatic wait_rv(input int k, input bit is_d, input int exp_lat, input string tag);
        int  n    = 0;
        bit  seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            smp();
            if ((is_d ? d_rvalid[k] : i_rvalid[k]) === 1'b1) begin
                seen = 1'b1;
                n    = c;
            end else begin
                step();
            end
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic set_d(input int k, input bit we, input logic [6:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        d_req[k]   = 1'b1;
        d_we[k]    = we;
        d_addr[k]  = addr;
        d_wdata[k] = wdata;
        d_be[k]    = be;
    endtask

    initial begin
        bit exp_d;
        for (int k = 0; k < N; k++) begin
            i_req[k] = 1'b0; i_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0;
        end

        // Reset: a request held during reset must not be granted.
        rst = 1'b1;
        i_req[0] = 1'b1; i_addr[0] = 7'd5;
        step(); step();
        smp();
        check("rst_i_gnt",  32'(i_gnt[0]), 32'd0);
        check("rst_ctrl",   32'({i_rvalid[0], d_gnt[0], d_rvalid[0], mem_en[0], mem_we[0]}), 32'd0);
        check("rst_bus",    32'({mem_be[0], mem_addr[0]}), 32'd0);
        check("rst_data",   i_rdata[0] | d_rdata[0] | mem_wdata[0], 32'd0);
        step();
        rst = 1'b0; i_req[0] = 1'b0;
        step();

        // LAT=1: store 0x00500093 to word 5, then fetch it back.
        set_d(0, 1'b1, 7'd5, 32'h0050_0093, 4'hF);
        smp();
        check("st5_gnt",   32'(d_gnt[0]), 32'd1);
        check("st5_we",    32'(mem_we[0]), 32'd1);
        check("st5_addr",  32'(mem_addr[0]), 32'd5);
        step(); d_req[0] = 1'b0;
        wait_rv(0, 1'b1, 1, "st5");
        check("st5_rdata", d_rdata[0], 32'd0);
        step();

        i_req[0] = 1'b1; i_addr[0] = 7'd5;
        smp();
        check("f5_gnt",    32'({i_gnt[0], d_gnt[0], mem_en[0], mem_we[0]}), 32'b1010);
        check("f5_addr",   32'(mem_addr[0]), 32'd5);
        check("f5_be",     32'(mem_be[0]), 32'hF);
        step(); i_req[0] = 1'b0;
        wait_rv(0, 1'b0, 1, "f5");
        check("f5_rdata",  i_rdata[0], 32'h0050_0093);
        check("f5_drv",    32'(d_rvalid[0]), 32'd0);
        step();

        // Store with upper byte enables only, then load it back.
        set_d(0, 1'b1, 7'd3, 32'hDEAD_BEEF, 4'b1100);
        smp();
        check("st3_gnt",   32'(d_gnt[0]), 32'd1);
        check("st3_be",    32'(mem_be[0]), 32'hC);
        check("st3_wdata", mem_wdata[0], 32'hDEAD_BEEF);
        step(); d_req[0] = 1'b0;
        wait_rv(0, 1'b1, 1, "st3");
        check("st3_rdata", d_rdata[0], 32'd0);
        step();

        set_d(0, 1'b0, 7'd3, 32'd0, 4'hF);
        smp();
        check("ld3_gnt",   32'({d_gnt[0], mem_we[0]}), 32'b10);
        step(); d_req[0] = 1'b0;
        wait_rv(0, 1'b1, 1, "ld3");
        check("ld3_rdata", d_rdata[0], 32'hDEAD_0000);
        step();

        // Contention: both requesters held for four transactions.
        i_req[0] = 1'b1; i_addr[0] = 7'd5;
        set_d(0, 1'b0, 7'd3, 32'd0, 4'hF);
        for (int t = 0; t < 4; t++) begin
            exp_d = RR ? (t % 2 == 1) : 1'b1;
            smp();
            check($sformatf("con%0d_gnt", t), 32'({i_gnt[0], d_gnt[0]}), 32'({!exp_d, exp_d}));
            step();
            smp();
            check($sformatf("con%0d_rv", t), 32'({i_gnt[0], d_gnt[0], i_rvalid[0], d_rvalid[0]}),
                  32'({2'b00, !exp_d, exp_d}));
            check($sformatf("con%0d_rdata", t), exp_d ? d_rdata[0] : i_rdata[0],
                  exp_d ? 32'hDEAD_0000 : 32'h0050_0093);
            step();
        end
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        step();

        // LAT=3: seed word 7, then a timed load with a store queued behind it.
        set_d(2, 1'b1, 7'd7, 32'h1234_5678, 4'hF);
        smp();
        check("l3_st7_gnt", 32'(d_gnt[2]), 32'd1);
        step(); d_req[2] = 1'b0;
        wait_rv(2, 1'b1, 3, "l3_st7");
        step();

        set_d(2, 1'b0, 7'd7, 32'd0, 4'hF);           // cycle 0
        smp();
        check("l3_c0", 32'({d_gnt[2], mem_en[2]}), 32'b11);
        step();
        set_d(2, 1'b1, 7'd8, 32'hA5A5_A5A5, 4'hF);   // cycle 1
        smp();
        check("l3_c1", 32'({d_gnt[2], mem_en[2], d_rvalid[2]}), 32'd0);
        step();                                       // cycle 2
        smp();
        check("l3_c2", 32'({d_gnt[2], mem_en[2], d_rvalid[2]}), 32'd0);
        step();                                       // cycle 3
        smp();
        check("l3_c3", 32'({d_gnt[2], mem_en[2], d_rvalid[2]}), 32'b001);
        check("l3_c3_rdata", d_rdata[2], 32'h1234_5678);
        step();                                       // cycle 4
        smp();
        check("l3_c4", 32'({d_gnt[2], mem_en[2], mem_we[2]}), 32'b111);
        check("l3_c4_addr", 32'(mem_addr[2]), 32'd8);
        step(); d_req[2] = 1'b0;
        wait_rv(2, 1'b1, 3, "l3_st8");
        check("l3_st8_rdata", d_rdata[2], 32'd0);
        step();

        // Withdrawn request: d_req pulses only during a WAIT cycle.
        i_req[2] = 1'b1; i_addr[2] = 7'd8;
        smp();
        check("wd_c0", 32'(i_gnt[2]), 32'd1);
        step();
        i_req[2] = 1'b0;
        set_d(2, 1'b0, 7'd7, 32'd0, 4'hF);
        smp();
        check("wd_c1", 32'({d_gnt[2], mem_en[2]}), 32'd0);
        step();
        d_req[2] = 1'b0;
        step();
        smp();
        check("wd_c3", 32'({i_rvalid[2], d_rvalid[2]}), 32'b10);
        check("wd_c3_rdata", i_rdata[2], 32'hA5A5_A5A5);
        step();
        smp();
        check("wd_c4", 32'({d_gnt[2], mem_en[2], d_rvalid[2]}), 32'd0);
        step();

        // LAT=2: reset lands during the WAIT of a fetch.
        i_req[1] = 1'b1; i_addr[1] = 7'd5;            // cycle 0
        smp();
        check("rm_c0", 32'(i_gnt[1]), 32'd1);
        step();
        i_req[1] = 1'b0; rst = 1'b1;                  // cycle 1
        smp();
        check("rm_c1", 32'(i_rvalid[1]), 32'd0);
        step();
        rst = 1'b0;                                   // cycle 2
        smp();
        check("rm_c2_ctrl", 32'({i_gnt[1], i_rvalid[1], d_gnt[1], d_rvalid[1],
                                 mem_en[1], mem_we[1], mem_be[1], mem_addr[1]}), 32'd0);
        check("rm_c2_data", i_rdata[1] | d_rdata[1] | mem_wdata[1], 32'd0);
        step();
        i_req[1] = 1'b1; i_addr[1] = 7'd9;            // cycle 3
        smp();
        check("rm_c3", 32'({i_gnt[1], mem_en[1]}), 32'b11);
        check("rm_c3_addr", 32'(mem_addr[1]), 32'd9);
        step(); i_req[1] = 1'b0;
        wait_rv(1, 1'b0, 2, "rm_f9");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
